control_transfer_sequencer: RTL and testbench

//  Multi-cycle sequencer for control-transfer instructions (BEQ..BGEU, JAL, JALR) in the
//  RV64I multicycle core. Accepts one instruction from the main control FSM, obtains the

---
 rtl/control_transfer_sequencer.sv | 177 +++++++++++++++++
 tb/tb_control_transfer_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/control_transfer_sequencer.sv
// Control-transfer sequencer for the RV64I multicycle core: resolves branches via the shared ALU,
// checks target alignment and drives registered PC-update controls. Build macro: RVC_SUPPORT_EN.
module control_transfer_sequencer #(
  parameter int XLEN        = 64,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            branch_en,
  input  logic            jal_en,
  input  logic            jalr_en,
  input  logic [2:0]      inst_funct3,
  input  logic [XLEN-1:0] target_addr,
  output logic            alu_req,
  input  logic            alu_ack,
  input  logic            alu_result_bit0,
  input  logic            alu_result_eq_zero,
  output logic            busy,
  output logic            done,
  output logic [1:0]      pc_sel,
  output logic            pc_write,
  output logic            misaligned_exc,
  output logic [XLEN-1:0] exc_addr,
  output logic            timeout_err
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [1:0] SEL_PC4  = 2'b00;
  localparam logic [1:0] SEL_IMM  = 2'b01;
  localparam logic [1:0] SEL_JALR = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMP,
    S_COMMIT,
    S_TRAP
  } state_t;

  state_t          state, state_d;
  logic [2:0]      f3_q, f3_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      sel_q, sel_d;
  logic            tmo_q, tmo_d;
  logic            jalr_q, jalr_d;
  logic            f3_ok;
  logic            taken;
  logic [XLEN-1:0] chk_addr;

  function automatic logic misaligned(input logic [1:0] lsb);
`ifdef RVC_SUPPORT_EN
    return lsb[0];
`else
    return lsb != 2'b00;
`endif
  endfunction

  // funct3 010/011 are not branch encodings; they fall through as not taken.
  assign f3_ok    = (inst_funct3[2:1] != 2'b01);
  assign chk_addr = jalr_q ? {target_addr[XLEN-1:1], 1'b0} : target_addr;

  always_comb begin
    taken = 1'b0;
    case (f3_q)
      3'b000:         taken = alu_result_eq_zero;
      3'b001:         taken = !alu_result_eq_zero;
      3'b100, 3'b110: taken = alu_result_bit0;
      3'b101, 3'b111: taken = !alu_result_bit0;
      default:        taken = 1'b0;
    endcase
  end

  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    state_d = state;
    f3_d    = f3_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    tmo_d   = tmo_q;
    jalr_d  = jalr_q;
    case (state)
      S_IDLE: begin
        if (start) begin
          tmo_d  = 1'b0;
          cnt_d  = '0;
          jalr_d = 1'b0;
          if (branch_en) begin
            f3_d = inst_funct3;
            if (f3_ok) begin
              state_d = S_CMP;
            end else begin
              sel_d   = SEL_PC4;
              state_d = S_COMMIT;
            end
          end else if (jal_en) begin
            sel_d   = SEL_IMM;
            state_d = misaligned(target_addr[1:0]) ? S_TRAP : S_COMMIT;
          end else if (jalr_en) begin
            jalr_d  = 1'b1;
            sel_d   = SEL_JALR;
            state_d = misaligned({target_addr[1], 1'b0}) ? S_TRAP : S_COMMIT;
          end else begin
            sel_d   = SEL_PC4;
            state_d = S_COMMIT;
          end
        end
      end
      S_CMP: begin
        if (alu_ack) begin
          if (!taken) begin
            sel_d   = SEL_PC4;
            state_d = S_COMMIT;
          end else if (misaligned(target_addr[1:0])) begin
            state_d = S_TRAP;
          end else begin
            sel_d   = SEL_IMM;
            state_d = S_COMMIT;
          end
        end else if (cnt_q >= CW'(ACK_TIMEOUT - 1)) begin
          // Final allowed cycle without ack: abort and fall through to PC+4.
          cnt_d   = CW'(ACK_TIMEOUT);
          tmo_d   = 1'b1;
          sel_d   = SEL_PC4;
          state_d = S_COMMIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_COMMIT, S_TRAP: state_d = S_IDLE;
      default:          state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      f3_q   <= '0;
      cnt_q  <= '0;
      sel_q  <= SEL_PC4;
      tmo_q  <= 1'b0;
      jalr_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state  <= state_d;
      f3_q   <= f3_d;
      cnt_q  <= cnt_d;
      sel_q  <= sel_d;
      tmo_q  <= tmo_d;
      jalr_q <= jalr_d;
    end
  end

  // Outputs are flopped; pc_sel and exc_addr only load on their own events and hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_req        <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pc_write       <= 1'b0;
      misaligned_exc <= 1'b0;
      timeout_err    <= 1'b0;
      pc_sel         <= SEL_PC4;
      exc_addr       <= '0;
    end else begin
      alu_req        <= (state_d == S_CMP);
      busy           <= (state_d != S_IDLE);
      done           <= (state == S_COMMIT) || (state == S_TRAP);
      pc_write       <= (state == S_COMMIT);
      misaligned_exc <= (state == S_TRAP);
      timeout_err    <= (state == S_COMMIT) && tmo_q;
      if (state == S_COMMIT) pc_sel <= sel_q;
      if (state == S_TRAP)   exc_addr <= chk_addr;
    end
  end

endmodule

// File: tb/tb_control_transfer_sequencer.sv
// Scoreboard bench for control_transfer_sequencer: directed vectors push expected completions,
// a negedge monitor pops and compares on every done pulse.
module tb_control_transfer_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, branch_en, jal_en, jalr_en;
  logic [2:0]  inst_funct3;
  logic [63:0] target_addr;
  logic        alu_req, alu_ack, alu_result_bit0, alu_result_eq_zero;
  logic        busy, done, pc_write, misaligned_exc, timeout_err;
  logic [1:0]  pc_sel;
  logic [63:0] exc_addr;

  control_transfer_sequencer #(.XLEN(64), .ACK_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .start(start), .branch_en(branch_en), .jal_en(jal_en),
    .jalr_en(jalr_en), .inst_funct3(inst_funct3), .target_addr(target_addr),
    .alu_req(alu_req), .alu_ack(alu_ack), .alu_result_bit0(alu_result_bit0),
    .alu_result_eq_zero(alu_result_eq_zero), .busy(busy), .done(done), .pc_sel(pc_sel),
    .pc_write(pc_write), .misaligned_exc(misaligned_exc), .exc_addr(exc_addr),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [1:0]  pc_sel;
    logic        pc_write;
    logic        mis;
    logic [63:0] exc_addr;
    logic        tmo;
    int unsigned due;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int          total = 0;
  int          passed = 0;
  int          stray = 0;
  logic [1:0]  model_sel = 2'b00;
  logic [63:0] model_exc = 64'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          mon_e = sb.pop_front();
          check($sformatf("v%0d.pc_sel", mon_e.id), pc_sel, mon_e.pc_sel);
          check($sformatf("v%0d.pc_write", mon_e.id), pc_write, mon_e.pc_write);
          check($sformatf("v%0d.misaligned_exc", mon_e.id), misaligned_exc, mon_e.mis);
          check($sformatf("v%0d.exc_addr", mon_e.id), exc_addr, mon_e.exc_addr);
          check($sformatf("v%0d.timeout_err", mon_e.id), timeout_err, mon_e.tmo);
          check($sformatf("v%0d.done_cycle", mon_e.id), cyc, mon_e.due);
        end
      end else if (pc_write || misaligned_exc || timeout_err) begin
        stray++;
      end
    end
  end

  // ack_at: alu_req cycle on which alu_ack is raised (0 = no ALU use, -1 = never).
  task automatic run_vec(input int id, input logic br, input logic jal, input logic jalr,
                         input logic [2:0] f3, input logic [63:0] tgt, input int ack_at,
                         input logic eq, input logic b0, input logic hold, input int exp_req,
                         input logic [1:0] exp_sel, input logic exp_pw, input logic exp_mis,
                         input logic [63:0] exp_exc, input logic exp_tmo, input int exp_lat);
    exp_t e;
    int   reqs;
    int   guard;
    @(posedge clk); #1;
    if (exp_pw)  model_sel = exp_sel;
    if (exp_mis) model_exc = exp_exc;
    e.id = id; e.pc_sel = model_sel; e.pc_write = exp_pw; e.mis = exp_mis;
    e.exc_addr = model_exc; e.tmo = exp_tmo; e.due = cyc + exp_lat;
    sb.push_back(e);
    start = 1'b1; branch_en = br; jal_en = jal; jalr_en = jalr;
    inst_funct3 = f3; target_addr = tgt;
    @(posedge clk); #1;
    check($sformatf("v%0d.busy", id), busy, 1'b1);
    start = hold; branch_en = 1'b0; jal_en = hold; jalr_en = 1'b0; inst_funct3 = 3'b000;
    reqs = 0;
    guard = 0;
    while (alu_req && guard < 40) begin
      reqs++;
      guard++;
      if (reqs == ack_at) begin
        alu_ack = 1'b1; alu_result_eq_zero = eq; alu_result_bit0 = b0;
      end
      @(posedge clk); #1;
      alu_ack = 1'b0;
    end
    start = 1'b0; jal_en = 1'b0;
    check($sformatf("v%0d.req_cycles", id), reqs, exp_req);
    guard = 0;
    while (sb.size() != 0 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    #1;
    check($sformatf("v%0d.drain", id), sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; branch_en = 1'b0; jal_en = 1'b0; jalr_en = 1'b0;
    inst_funct3 = 3'b000; target_addr = 64'h0; alu_ack = 1'b0;
    alu_result_bit0 = 1'b0; alu_result_eq_zero = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.busy", busy, 1'b0);
    check("reset.alu_req", alu_req, 1'b0);
    check("reset.done", done, 1'b0);
    check("reset.pc_sel", pc_sel, 2'b00);
    check("reset.exc_addr", exc_addr, 64'h0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    //      id br jal jalr f3      target     ack eq b0 hold req sel    pw mis exc        tmo lat
    run_vec( 1, 1, 0, 0, 3'b000, 64'h1000,   3, 1, 0, 0,  3, 2'b01, 1, 0, 64'h0,    0,  5);
    run_vec( 2, 1, 0, 0, 3'b111, 64'h1000,   1, 0, 1, 0,  1, 2'b00, 1, 0, 64'h0,    0,  3);
`ifdef RVC_SUPPORT_EN
    run_vec( 3, 0, 1, 0, 3'b000, 64'h1002,   0, 0, 0, 0,  0, 2'b01, 1, 0, 64'h0,    0,  2);
`else
    run_vec( 3, 0, 1, 0, 3'b000, 64'h1002,   0, 0, 0, 0,  0, 2'b00, 0, 1, 64'h1002, 0,  2);
`endif
    run_vec( 4, 0, 0, 1, 3'b000, 64'h2001,   0, 0, 0, 0,  0, 2'b10, 1, 0, 64'h0,    0,  2);
    run_vec( 5, 1, 0, 0, 3'b100, 64'h1000,  -1, 0, 0, 0, 15, 2'b00, 1, 0, 64'h0,    1, 17);
    run_vec( 6, 1, 0, 0, 3'b001, 64'h3004,   2, 0, 0, 0,  2, 2'b01, 1, 0, 64'h0,    0,  4);
    run_vec( 7, 0, 0, 0, 3'b000, 64'h3004,   0, 0, 0, 0,  0, 2'b00, 1, 0, 64'h0,    0,  2);
    run_vec( 8, 1, 0, 0, 3'b001, 64'h3005,   1, 0, 0, 0,  1, 2'b00, 0, 1, 64'h3005, 0,  3);
    run_vec( 9, 1, 0, 0, 3'b110, 64'h3005,   1, 0, 0, 0,  1, 2'b00, 1, 0, 64'h0,    0,  3);
    run_vec(10, 0, 1, 1, 3'b000, 64'h4000,   0, 0, 0, 0,  0, 2'b01, 1, 0, 64'h0,    0,  2);
    run_vec(11, 1, 0, 0, 3'b010, 64'h3005,   0, 0, 0, 0,  0, 2'b00, 1, 0, 64'h0,    0,  2);
`ifdef RVC_SUPPORT_EN
    run_vec(12, 0, 0, 1, 3'b000, 64'h2002,   0, 0, 0, 0,  0, 2'b10, 1, 0, 64'h0,    0,  2);
`else
    run_vec(12, 0, 0, 1, 3'b000, 64'h2002,   0, 0, 0, 0,  0, 2'b00, 0, 1, 64'h2002, 0,  2);
`endif
    run_vec(13, 1, 1, 0, 3'b000, 64'h4000,   1, 0, 0, 0,  1, 2'b00, 1, 0, 64'h0,    0,  3);
    run_vec(14, 1, 0, 0, 3'b101, 64'h5000,  15, 0, 0, 0, 15, 2'b01, 1, 0, 64'h0,    0, 17);

    // Reset while the compare is outstanding: no completion may follow.
    @(posedge clk); #1;
    start = 1'b1; branch_en = 1'b1; inst_funct3 = 3'b000; target_addr = 64'h7000;
    @(posedge clk); #1;
    start = 1'b0; branch_en = 1'b0;
    @(posedge clk); #1;
    check("midrst.alu_req_before", alu_req, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("midrst.busy", busy, 1'b0);
    check("midrst.alu_req", alu_req, 1'b0);
    check("midrst.pc_sel", pc_sel, 2'b00);
    check("midrst.exc_addr", exc_addr, 64'h0);
    check("midrst.done", done, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_sel = 2'b00;
    model_exc = 64'h0;
    repeat (4) @(posedge clk);

    //      id br jal jalr f3      target     ack eq b0 hold req sel    pw mis exc        tmo lat
    run_vec(15, 1, 0, 0, 3'b000, 64'h6000,   4, 1, 0, 1,  4, 2'b01, 1, 0, 64'h0,    0,  6);
    run_vec(16, 0, 0, 1, 3'b000, 64'h6008,   0, 0, 0, 0,  0, 2'b10, 1, 0, 64'h0,    0,  2);

    repeat (4) @(posedge clk);
    #1;
    check("stray_pulses", stray, 0);
    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
